// File: rtl/mem_line_obi_arbiter_if.sv
// Bundles the cache-side line channels and the 32-bit OBI master port of
// mem_line_obi_arbiter.
//   slave  : the arbiter's view (accepts line requests, drives OBI requests)
//   master : the environment's view (cache channels plus OBI memory)
// Channel request/response signals are per-channel packed vectors. The
// response data and tag are shared by all channels and qualified by
// ch_rsp_valid_o.
interface mem_line_obi_arbiter_if #(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned LINE_WIDTH = 512,
    parameter int unsigned ADDR_WIDTH = 26,
    parameter int unsigned TAG_WIDTH  = 8
);
    localparam int unsigned BE_WIDTH = LINE_WIDTH / 8;

    logic [NUM_CH-1:0]                  ch_req_valid_i;
    logic [NUM_CH-1:0]                  ch_req_ready_o;
    logic [NUM_CH-1:0]                  ch_req_rw_i;
    logic [NUM_CH-1:0][ADDR_WIDTH-1:0]  ch_req_addr_i;
    logic [NUM_CH-1:0][BE_WIDTH-1:0]    ch_req_byteen_i;
    logic [NUM_CH-1:0][LINE_WIDTH-1:0]  ch_req_data_i;
    logic [NUM_CH-1:0][TAG_WIDTH-1:0]   ch_req_tag_i;
    logic [NUM_CH-1:0]                  ch_rsp_valid_o;
    logic [NUM_CH-1:0]                  ch_rsp_ready_i;
    logic [LINE_WIDTH-1:0]              ch_rsp_data_o;
    logic [TAG_WIDTH-1:0]               ch_rsp_tag_o;

    logic                               obi_req_o;
    logic                               obi_gnt_i;
    logic [31:0]                        obi_addr_o;
    logic                               obi_we_o;
    logic [3:0]                         obi_be_o;
    logic [31:0]                        obi_wdata_o;
    logic                               obi_rvalid_i;
    logic [31:0]                        obi_rdata_i;

    modport slave (
        input  ch_req_valid_i, ch_req_rw_i, ch_req_addr_i, ch_req_byteen_i,
        input  ch_req_data_i, ch_req_tag_i, ch_rsp_ready_i,
        output ch_req_ready_o, ch_rsp_valid_o, ch_rsp_data_o, ch_rsp_tag_o,
        output obi_req_o, obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o,
        input  obi_gnt_i, obi_rvalid_i, obi_rdata_i
    );

    modport master (
        output ch_req_valid_i, ch_req_rw_i, ch_req_addr_i, ch_req_byteen_i,
        output ch_req_data_i, ch_req_tag_i, ch_rsp_ready_i,
        input  ch_req_ready_o, ch_rsp_valid_o, ch_rsp_data_o, ch_rsp_tag_o,
        input  obi_req_o, obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o,
        output obi_gnt_i, obi_rvalid_i, obi_rdata_i
    );
endinterface

// File: rtl/mem_line_obi_arbiter.sv
// Round-robin arbiter that serialises cache-line requests from NUM_CH
// channels onto a single 32-bit OBI master, one beat outstanding at a time.
// Reads gather BEATS words into a line buffer and return it on the
// requesting channel; writes skip beats with no byte enables and return
// nothing.
// Ports:
//   clk_i : clock, rising edge
//   rst_i : synchronous active-high reset
//   bus   : channel request/response handshakes and OBI master signals
module mem_line_obi_arbiter #(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned LINE_WIDTH = 512,
    parameter int unsigned ADDR_WIDTH = 26,
    parameter int unsigned TAG_WIDTH  = 8
) (
    input logic                    clk_i,
    input logic                    rst_i,
    mem_line_obi_arbiter_if.slave  bus
);
    localparam int unsigned BEATS    = LINE_WIDTH / 32;
    localparam int unsigned BE_WIDTH = LINE_WIDTH / 8;
    localparam int unsigned OFS_W    = $clog2(BE_WIDTH);
    localparam int unsigned BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned BYTE_AW  = ADDR_WIDTH + OFS_W;

    typedef enum logic [1:0] {IDLE, SEND, WAIT_R, RESP} state_t;

    state_t                  state_q, state_d;
    logic [CH_W-1:0]         last_q, ch_q;
    logic                    rw_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [BE_WIDTH-1:0]     byteen_q;
    logic [LINE_WIDTH-1:0]   data_q;
    logic [TAG_WIDTH-1:0]    tag_q;
    logic [BEAT_W-1:0]       beat_q;

    logic                    gnt_found;
    logic [CH_W-1:0]         gnt_idx, cand;
    logic [BEATS-1:0]        beat_active;
    logic                    send_found, more_found;
    logic [BEAT_W-1:0]       send_beat;
    logic                    accept, beat_granted, beat_done;
    logic [BYTE_AW-1:0]      byte_base;

    // Round-robin search beginning one past the last granted channel
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            cand = CH_W'((32'(last_q) + i + 32'd1) % NUM_CH);
            if (!gnt_found && bus.ch_req_valid_i[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // Beats that need an OBI transfer: all of them on reads, enabled ones on writes.
    // send_beat is the next such beat at or after beat_q; more_found says one
    // exists strictly after beat_q (i.e. the beat in flight is not the last).
    always_comb begin
        beat_active = '0;
        send_found  = 1'b0;
        send_beat   = '0;
        more_found  = 1'b0;
        for (int unsigned b = 0; b < BEATS; b++) begin
            beat_active[b] = !rw_q || (|byteen_q[b*4 +: 4]);
            if (!send_found && beat_active[b] && (b >= 32'(beat_q))) begin
                send_found = 1'b1;
                send_beat  = BEAT_W'(b);
            end
            if (beat_active[b] && (b > 32'(beat_q))) begin
                more_found = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and channel/OBI outputs
    always_comb begin
        state_d            = state_q;
        accept             = 1'b0;
        beat_granted       = 1'b0;
        beat_done          = 1'b0;
        bus.ch_req_ready_o = '0;
        bus.ch_rsp_valid_o = '0;
        bus.obi_req_o      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (gnt_found) begin
                    accept  = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                // send_found is only ever false for a write with no enabled bytes
                if (!send_found) begin
                    state_d = IDLE;
                end else if (bus.obi_gnt_i) begin
                    beat_granted = 1'b1;
                    state_d      = WAIT_R;
                end
            end
            WAIT_R: begin
                if (bus.obi_rvalid_i) begin
                    beat_done = 1'b1;
                    if (more_found) begin
                        state_d = SEND;
                    end else if (rw_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (bus.ch_rsp_ready_i[ch_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Handshake outputs are forced low while reset is asserted
        if (!rst_i) begin
            if (state_q == IDLE && gnt_found) begin
                bus.ch_req_ready_o[gnt_idx] = 1'b1;
            end
            if (state_q == RESP) begin
                bus.ch_rsp_valid_o[ch_q] = 1'b1;
            end
            bus.obi_req_o = (state_q == SEND) && send_found;
        end
    end

    // OBI beat payload, stable for as long as beat_q and the captured request are
    assign byte_base         = {addr_q, {OFS_W{1'b0}}};
    assign bus.obi_addr_o    = 32'(byte_base) + 32'({send_beat, 2'b00});
    assign bus.obi_we_o      = rw_q;
    assign bus.obi_be_o      = rw_q ? byteen_q[32'(send_beat)*4 +: 4] : 4'hF;
    assign bus.obi_wdata_o   = data_q[32'(send_beat)*32 +: 32];
    assign bus.ch_rsp_data_o = data_q;
    assign bus.ch_rsp_tag_o  = tag_q;

    // Request capture, beat tracking and read line assembly
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q   <= CH_W'(NUM_CH - 1);
            ch_q     <= '0;
            rw_q     <= 1'b0;
            addr_q   <= '0;
            byteen_q <= '0;
            data_q   <= '0;
            tag_q    <= '0;
            beat_q   <= '0;
        end else begin
            if (accept) begin
                rw_q     <= bus.ch_req_rw_i[gnt_idx];
                addr_q   <= bus.ch_req_addr_i[gnt_idx];
                byteen_q <= bus.ch_req_byteen_i[gnt_idx];
                data_q   <= bus.ch_req_data_i[gnt_idx];
                tag_q    <= bus.ch_req_tag_i[gnt_idx];
                ch_q     <= gnt_idx;
                last_q   <= gnt_idx;
                beat_q   <= '0;
            end
            // beat_q tracks the beat actually in flight once granted
            if (beat_granted) begin
                beat_q <= send_beat;
            end
            if (beat_done) begin
                if (!rw_q) begin
                    data_q[32'(beat_q)*32 +: 32] <= bus.obi_rdata_i;
                end
                if (more_found) begin
                    beat_q <= beat_q + BEAT_W'(1);
                end
            end
        end
    end
endmodule

// File: doc/mem_line_obi_arbiter.md
MEM_LINE_OBI_ARBITER -- requirements
Module: mem_line_obi_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of cache-side channels, 1..8.
REQ-002 SHALL have parameter LINE_WIDTH, default 512: cache line width in bits, a multiple of 32.
REQ-003 SHALL have parameter ADDR_WIDTH, default 26: line address width.
REQ-004 SHALL have parameter TAG_WIDTH, default 8: request tag width.
REQ-005 SHALL have port clk_i  in  1  sole clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_i  in  1  reset, synchronous and active-high.
REQ-007 SHALL have ch_req_valid_i / ch_req_ready_o  in/out  NUM_CH  per-channel line request handshake.
REQ-008 SHALL have ch_req_rw_i  in  NUM_CH  1 = write, 0 = read.
REQ-009 SHALL have ch_req_addr_i  in  NUM_CH x ADDR_WIDTH  line address.
REQ-010 SHALL have ch_req_byteen_i  in  NUM_CH x LINE_WIDTH/8  write byte enables.
REQ-011 SHALL have ch_req_data_i  in  NUM_CH x LINE_WIDTH  write data.
REQ-012 SHALL have ch_req_tag_i  in  NUM_CH x TAG_WIDTH  request tag.
REQ-013 SHALL have ch_rsp_valid_o / ch_rsp_ready_i  out/in  NUM_CH  per-channel read response handshake.
REQ-014 SHALL have ch_rsp_data_o  out  LINE_WIDTH  and ch_rsp_tag_o  out  TAG_WIDTH, shared by all channels, qualified by ch_rsp_valid_o.
REQ-015 SHALL have OBI master ports obi_req_o out 1, obi_gnt_i in 1, obi_addr_o out 32, obi_we_o out 1, obi_be_o out 4, obi_wdata_o out 32, obi_rvalid_i in 1, obi_rdata_i in 32.

Function
REQ-016 SHALL use FSM states IDLE, SEND, WAIT_R, RESP; BEATS = LINE_WIDTH/32.
REQ-017 SHALL in IDLE grant exactly one valid channel round-robin, starting the search at (last granted + 1) mod NUM_CH; ch_req_ready_o high only for that channel, only in IDLE.
REQ-018 SHALL on accept capture rw, addr, byteen, data, tag, channel index; record the channel as last granted; clear beat counter; go to SEND.
REQ-019 SHALL form obi_addr_o = ((addr << log2(LINE_WIDTH/8)) + beat*4), truncated to 32 bits.
REQ-020 SHALL drive obi_be_o = 4'hF on reads and the beat's 4 byte enables on writes; obi_wdata_o = beat's 32-bit slice, beat 0 = bits [31:0].
REQ-021 SHALL on writes skip beats whose 4 byte enables are zero; no OBI request is issued for them.
REQ-022 SHALL in SEND hold obi_req_o high with stable addr/we/be/wdata until obi_gnt_i; on grant go to WAIT_R with obi_req_o low from the next cycle.
REQ-023 SHALL allow at most one outstanding OBI beat; WAIT_R waits for obi_rvalid_i, storing obi_rdata_i into the beat's slice on reads.
REQ-024 SHALL on rvalid of a non-final beat go to SEND for the next non-skipped beat, asserting obi_req_o in the following cycle.
REQ-025 SHALL on rvalid of the final issued beat go to RESP for reads and to IDLE for writes; writes produce no channel response.
REQ-026 SHALL for a write with all byte enables zero return from SEND to IDLE the cycle after accept, with no OBI traffic.
REQ-027 SHALL in RESP assert ch_rsp_valid_o for the captured channel only, holding data and tag stable until ch_rsp_ready_i, then go to IDLE.
REQ-028 SHALL ignore obi_rvalid_i outside WAIT_R and obi_gnt_i outside SEND.
REQ-029 SHALL take minimum read latency 1 + 2*BEATS cycles from accept to ch_rsp_valid_o with zero-wait-state memory.

Reset
REQ-030 SHALL on rst_i return to IDLE; obi_req_o, ch_req_ready_o, and ch_rsp_valid_o read 0 in the reset cycle; last granted = NUM_CH-1.
REQ-031 SHALL abandon any in-flight transaction on reset mid-operation, with no channel response, and ignore late rvalid.

Verification
REQ-032 Reset: rst_i high 3 cycles, both channels valid -> obi_req_o=0, ch_rsp_valid_o=0, first grant to ch0.
REQ-033 Read, NUM_CH=2, LINE_WIDTH=128, ch0 addr 0x10, zero-wait memory -> obi_addr_o 0x100,0x104,0x108,0x10C; rsp on ch0 with the 4 words at cycle 9, tag echoed.
REQ-034 Fairness: ch0 and ch1 continuously valid -> grants alternate ch0,ch1,ch0,ch1.
REQ-035 Sparse write: byteen 0x00F0 on LINE_WIDTH=128 -> exactly one OBI beat, addr base+4, be=4'hF; all-zero byteen -> no OBI req, ready again 2 cycles after accept.
REQ-036 Backpressure: obi_gnt_i low 5 cycles, then ch_rsp_ready_i low 4 cycles -> addr/be stable throughout, rsp data/tag stable, no duplicate beats.
REQ-037 Reset in WAIT_R, then rvalid pulse -> no channel response, FSM IDLE, next request processed normally.
